// File: rtl/fifo_delay_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_delay_ctrl
//
// Purpose:
//    Front-end controller for one shared FIFO.
//    Write side: a round-robin arbiter admits at most one of NUM_REQ producers
//    per cycle into the FIFO.
//    Read side: a pacing FSM waits cfg_delay cycles after it sees the FIFO
//    non-empty, pops one word, and then presents that word on a valid/ready
//    output until the consumer takes it.
//
// Ports:
//    clk           : clock, all state changes on the rising edge
//    rst           : synchronous active-high reset
//    req_valid     : per-producer "word available"
//    req_data      : producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//    req_ready     : one-hot grant, granted word is written this cycle
//    fifo_write_en : FIFO write enable
//    fifo_data_in  : FIFO write data (0 when nothing is granted)
//    fifo_full     : FIFO full flag
//    fifo_read_en  : FIFO read enable
//    fifo_empty    : FIFO empty flag
//    fifo_data_out : FIFO read data, valid the cycle after fifo_read_en
//    cfg_delay     : pacing delay in cycles, 0 means no wait
//    out_valid     : out_data holds a delivered word
//    out_data      : delivered word, 0 when out_valid is low
//    out_ready     : consumer accepts when out_valid & out_ready
// ---------------------------------------------------------------------------
module fifo_delay_ctrl #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 4,
   parameter int DELAY_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_write_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_full,
   output logic                          fifo_read_en,
   input  logic                          fifo_empty,
   input  logic [DATA_WIDTH-1:0]         fifo_data_out,
   input  logic [DELAY_WIDTH-1:0]        cfg_delay,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   input  logic                          out_ready
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_READ,
      ST_HOLD
   } state_t;

   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       grant_idx;
   logic [PTR_W-1:0]       cand_idx;
   logic                   grant_found;
   state_t                 state;
   state_t                 state_next;
   logic [DELAY_WIDTH-1:0] cnt;
   logic [DELAY_WIDTH-1:0] cnt_next;

   // Round-robin search: walk the producers starting at rr_ptr and take the
   // first one that has a word. A full FIFO or an active reset blocks every
   // grant, so producers simply keep holding their word.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_idx    = '0;
      if (!rst && !fifo_full) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
               grant_found = 1'b1;
               grant_idx   = cand_idx;
            end
         end
      end
   end

   // Turn the winning index into the one-hot ready and steer its word to the
   // FIFO. The write data is forced to zero when nobody wins so the FIFO bus
   // stays quiet.
   always_comb begin
      req_ready     = '0;
      fifo_data_in  = '0;
      fifo_write_en = grant_found;
      if (grant_found) begin
         req_ready[grant_idx] = 1'b1;
         fifo_data_in         = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // The pointer moves to the producer just after the winner, so the winner
   // becomes lowest priority next time. Without a grant the pointer holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (grant_found) begin
         rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
   end

   // Read-side state register. cnt is only meaningful in ST_WAIT, where it
   // holds the number of wait cycles still to go.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Pacing FSM. Leaving IDLE or HOLD with data waiting goes straight to READ
   // when the delay is zero, so WAIT is never entered with a zero count.
   // cfg_delay is captured only on the way into WAIT. The read strobe is also
   // qualified by fifo_empty so that a FIFO emptied behind our back just
   // sends us back to IDLE instead of popping nothing. Reset masks every
   // output so no handshake completes in the reset cycle.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      fifo_read_en = 1'b0;
      out_valid    = 1'b0;
      out_data     = '0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (cfg_delay == '0) begin
                  state_next = ST_READ;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = cfg_delay;
               end
            end
         end
         ST_WAIT: begin
            cnt_next = cnt - DELAY_WIDTH'(1);
            if (cnt == DELAY_WIDTH'(1)) begin
               state_next = ST_READ;
            end
         end
         ST_READ: begin
            if (!fifo_empty) begin
               fifo_read_en = 1'b1;
               state_next   = ST_HOLD;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            out_data  = fifo_data_out;
            if (out_ready) begin
               if (fifo_empty) begin
                  state_next = ST_IDLE;
               end else if (cfg_delay == '0) begin
                  state_next = ST_READ;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = cfg_delay;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (rst) begin
         fifo_read_en = 1'b0;
         out_valid    = 1'b0;
         out_data     = '0;
      end
   end

endmodule

// File: tb/tb_fifo_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_delay_ctrl
//
// Purpose:
//    Drives fifo_delay_ctrl with directed scenarios (reset, round-robin order,
//    full blocking, pacing delay, backpressure, reset while waiting) followed
//    by a randomized producer/consumer run checked against a grant model and
//    an in-order delivery scoreboard. An 8-deep FIFO model sits on the FIFO
//    ports; its full flag can be forced to exercise the write blocking.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_fifo_delay_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_write_en;
   logic [3:0]  fifo_data_in;
   logic        fifo_full;
   logic        fifo_read_en;
   logic        fifo_empty;
   logic [3:0]  fifo_data_out;
   logic [3:0]  cfg_delay;
   logic        out_valid;
   logic [3:0]  out_data;
   logic        out_ready;

   logic        forceFull;
   int          errors;
   int          checks;
   int          mRr;
   int          expG;
   logic        genOn;
   logic [3:0]  expQ[$];
   logic [3:0]  pv;
   logic [3:0]  pd[4];

   logic [3:0]  mem[8];
   logic [2:0]  wp;
   logic [2:0]  rp;
   logic [3:0]  count;
   logic [3:0]  doutReg;
   logic        doWr;
   logic        doRd;

   fifo_delay_ctrl #(
      .NUM_REQ(4),
      .DATA_WIDTH(4),
      .DELAY_WIDTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .fifo_write_en(fifo_write_en),
      .fifo_data_in(fifo_data_in),
      .fifo_full(fifo_full),
      .fifo_read_en(fifo_read_en),
      .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out),
      .cfg_delay(cfg_delay),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO model flags. The forced-full input lets the bench block writes
   // without having to fill the storage first.
   assign doWr          = fifo_write_en && (count != 4'd8);
   assign doRd          = fifo_read_en && (count != 4'd0);
   assign fifo_full     = (count == 4'd8) || forceFull;
   assign fifo_empty    = (count == 4'd0);
   assign fifo_data_out = doutReg;

   // FIFO model storage: registered read data, cleared together with the
   // controller on reset.
   always @(posedge clk) begin
      if (rst) begin
         wp      <= 3'd0;
         rp      <= 3'd0;
         count   <= 4'd0;
         doutReg <= 4'd0;
      end else begin
         if (doWr) begin
            mem[wp] <= fifo_data_in;
            wp      <= wp + 3'd1;
         end
         if (doRd) begin
            doutReg <= mem[rp];
            rp      <= rp + 3'd1;
         end
         count <= count + {3'd0, doWr} - {3'd0, doRd};
      end
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   // One comparison: counts it, and on mismatch counts the failure and
   // reports tag, observed and expected values.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to the next falling edge, apply one cycle of inputs, and let the
   // combinational outputs settle before any checks.
   task automatic applyStimulus(input logic [3:0] v, input logic [15:0] d,
                                input logic full, input logic rdy,
                                input logic [3:0] dly);
      @(negedge clk);
      req_valid = v;
      req_data  = d;
      forceFull = full;
      out_ready = rdy;
      cfg_delay = dly;
      #1;
   endtask

   // Two-cycle reset with quiet inputs.
   task automatic doReset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'd0;
      req_data  = 16'd0;
      forceFull = 1'b0;
      out_ready = 1'b0;
      cfg_delay = 4'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mRr = 0;
      #1;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      mRr       = 0;
      pv        = 4'd0;
      genOn     = 1'b0;
      for (int i = 0; i < 4; i++) pd[i] = 4'd0;
      rst       = 1'b1;
      req_valid = 4'hF;
      req_data  = 16'h4321;
      forceFull = 1'b0;
      out_ready = 1'b1;
      cfg_delay = 4'd0;

      // Power-on reset with every producer requesting.
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("por_req_ready", req_ready, 4'd0);
      checkOutput("por_write_en", fifo_write_en, 1'b0);
      checkOutput("por_read_en", fifo_read_en, 1'b0);
      checkOutput("por_out_valid", out_valid, 1'b0);
      doReset();

      // Reset while holding a word with data still queued in the FIFO.
      applyStimulus(4'b0001, 16'h0005, 1'b0, 1'b0, 4'd0);
      checkOutput("t1_grant_a", req_ready, 4'b0001);
      applyStimulus(4'b0001, 16'h0006, 1'b0, 1'b0, 4'd0);
      checkOutput("t1_grant_b", req_ready, 4'b0001);
      applyStimulus(4'b0001, 16'h0007, 1'b0, 1'b0, 4'd0);
      checkOutput("t1_read_en", fifo_read_en, 1'b1);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'hF;
      #1;
      checkOutput("t1_req_ready", req_ready, 4'd0);
      checkOutput("t1_write_en", fifo_write_en, 1'b0);
      checkOutput("t1_read_en_rst", fifo_read_en, 1'b0);
      checkOutput("t1_out_valid", out_valid, 1'b0);
      checkOutput("t1_out_data", out_data, 4'd0);
      doReset();

      // Round-robin order with all producers requesting, then a sparse mask.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 16'h4321, 1'b0, 1'b0, 4'd0);
         checkOutput("t2_rr_grant", req_ready, 32'd1 << (i % 4));
         checkOutput("t2_rr_data", fifo_data_in, (i % 4) + 1);
      end
      applyStimulus(4'b0010, 16'h4321, 1'b0, 1'b0, 4'd0);
      checkOutput("t2_set_ptr2", req_ready, 4'b0010);
      applyStimulus(4'b1010, 16'h4321, 1'b0, 1'b0, 4'd0);
      checkOutput("t2_sparse_3", req_ready, 4'b1000);
      applyStimulus(4'b1010, 16'h4321, 1'b0, 1'b0, 4'd0);
      checkOutput("t2_sparse_1", req_ready, 4'b0010);
      doReset();

      // Full FIFO blocks every grant and freezes the pointer.
      applyStimulus(4'b0010, 16'h4321, 1'b0, 1'b0, 4'd0);
      checkOutput("t3_pre_grant", req_ready, 4'b0010);
      applyStimulus(4'b0001, 16'h4321, 1'b1, 1'b0, 4'd0);
      checkOutput("t3_full_ready", req_ready, 4'd0);
      checkOutput("t3_full_wen", fifo_write_en, 1'b0);
      checkOutput("t3_full_data", fifo_data_in, 4'd0);
      applyStimulus(4'b1111, 16'h4321, 1'b1, 1'b0, 4'd0);
      checkOutput("t3_full_ready_all", req_ready, 4'd0);
      applyStimulus(4'b1111, 16'h4321, 1'b0, 1'b0, 4'd0);
      checkOutput("t3_release_ptr", req_ready, 4'b0100);
      applyStimulus(4'b0001, 16'h4321, 1'b0, 1'b0, 4'd0);
      checkOutput("t3_release_g0", req_ready, 4'b0001);
      doReset();

      // Pacing delay of 3; later cfg_delay changes must not matter.
      applyStimulus(4'b0001, 16'h000A, 1'b0, 1'b1, 4'd3);
      checkOutput("t4_write", req_ready, 4'b0001);
      for (int c = 1; c <= 7; c++) begin
         applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b1, (c == 1) ? 4'd3 : 4'd7);
         checkOutput("t4_read_en", fifo_read_en, (c == 5) ? 1 : 0);
         checkOutput("t4_out_valid", out_valid, (c == 6) ? 1 : 0);
         checkOutput("t4_out_data", out_data, (c == 6) ? 32'hA : 32'h0);
      end
      doReset();

      // Backpressure with zero delay and two queued words.
      applyStimulus(4'b0001, 16'h0001, 1'b0, 1'b0, 4'd0);
      applyStimulus(4'b0001, 16'h0002, 1'b0, 1'b0, 4'd0);
      checkOutput("t5_idle_no_read", fifo_read_en, 1'b0);
      applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b0, 4'd0);
      checkOutput("t5_first_read", fifo_read_en, 1'b1);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b0, 4'd0);
         checkOutput("t5_stall_valid", out_valid, 1'b1);
         checkOutput("t5_stall_data", out_data, 4'h1);
         checkOutput("t5_stall_no_read", fifo_read_en, 1'b0);
      end
      applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b1, 4'd0);
      checkOutput("t5_accept_data", out_data, 4'h1);
      applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b1, 4'd0);
      checkOutput("t5_second_read", fifo_read_en, 1'b1);
      checkOutput("t5_gap_valid", out_valid, 1'b0);
      applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b1, 4'd0);
      checkOutput("t5_second_valid", out_valid, 1'b1);
      checkOutput("t5_second_data", out_data, 4'h2);
      applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b1, 4'd0);
      checkOutput("t5_done_valid", out_valid, 1'b0);
      doReset();

      // Reset while waiting with two cycles left, then a fresh paced word.
      applyStimulus(4'b0001, 16'h000C, 1'b0, 1'b1, 4'd3);
      applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b1, 4'd3);
      applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b1, 4'd3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_read_en", fifo_read_en, 1'b0);
      checkOutput("t6_rst_out_valid", out_valid, 1'b0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 4'b0001;
      req_data  = 16'h000D;
      #1;
      checkOutput("t6_after_read_en", fifo_read_en, 1'b0);
      checkOutput("t6_after_out_valid", out_valid, 1'b0);
      checkOutput("t6_after_grant", req_ready, 4'b0001);
      for (int c = 5; c <= 10; c++) begin
         applyStimulus(4'b0000, 16'h0000, 1'b0, 1'b1, 4'd3);
         checkOutput("t6_read_en", fifo_read_en, (c == 9) ? 1 : 0);
         checkOutput("t6_out_valid", out_valid, (c == 10) ? 1 : 0);
         checkOutput("t6_out_data", out_data, (c == 10) ? 32'hD : 32'h0);
      end
      doReset();

      // Randomized producers and consumer, then a drain with out_ready high.
      pv = 4'd0;
      expQ.delete();
      for (int cyc = 0; cyc < 300; cyc++) begin
         genOn = (cyc < 200);
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (genOn && !pv[i] && ($urandom_range(2) == 0)) begin
               pv[i] = 1'b1;
               pd[i] = 4'($urandom);
            end
         end
         req_valid = pv;
         for (int i = 0; i < 4; i++) req_data[i*4 +: 4] = pd[i];
         out_ready = genOn ? ($urandom_range(3) != 0) : 1'b1;
         forceFull = genOn && ($urandom_range(7) == 0);
         if (genOn && ($urandom_range(15) == 0)) cfg_delay = 4'($urandom_range(3));
         #1;
         expG = -1;
         if (!fifo_full) begin
            for (int k = 0; k < 4; k++) begin
               if (expG < 0 && pv[(mRr + k) % 4]) expG = (mRr + k) % 4;
            end
         end
         checkOutput("rnd_grant", req_ready, (expG < 0) ? 32'd0 : (32'd1 << expG));
         if (expG >= 0) begin
            checkOutput("rnd_wdata", fifo_data_in, pd[expG]);
            expQ.push_back(pd[expG]);
            pv[expG] = 1'b0;
            mRr = (expG + 1) % 4;
         end
         checkOutput("rnd_read_in_hold", fifo_read_en & out_valid, 1'b0);
         if (!out_valid) begin
            checkOutput("rnd_idle_data", out_data, 4'd0);
         end else if (out_ready) begin
            if (expQ.size() == 0) checkOutput("rnd_spurious_valid", out_valid, 1'b0);
            else checkOutput("rnd_deliver", out_data, expQ.pop_front());
         end
      end
      checkOutput("drain_queue_empty", expQ.size(), 0);
      checkOutput("drain_no_pending", pv, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
